demux_router: RTL and testbench

Registered 1-to-N demultiplexer: the receive-side counterpart of the team's 2:1 `mux`. It takes one valid/ready word stream and steers each accepted word to one of `CHANNELS` output ports. Each output port has a one-entry holding register and its own valid/ready handshake. It sits after a shared link or arbiter, where a single word stream must be fanned back out to per-channel consumers.

---
 rtl/demux_router.sv | 158 +++++++++++++++
 tb/tb_demux_router.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_router.sv
// demux_router: registered 1-to-N demultiplexer for a valid/ready word stream.
// Each accepted word is steered to one of CHANNELS output ports. Every port
// owns a one-entry holding register with its own valid/ready handshake.
// Words addressed to a non-existent channel are accepted, discarded and
// counted in a saturating 8-bit drop counter.
//
// Optional build macro DEMUX_ROUNDROBIN_EN: when defined, in_sel is ignored
// and an internal pointer walks the channels 0..CHANNELS-1, advancing on
// every accepted word. When undefined, routing follows in_sel.
module demux_router #(
    parameter int  WIDTH    = 8,
    parameter int  CHANNELS = 4,
    localparam int SEL_W    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [7:0]                drop_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_e;

    // Channel count widened by one bit so an out-of-range select compares cleanly.
    localparam logic [SEL_W:0] CHAN_LIM = (SEL_W + 1)'(CHANNELS);

    logic [SEL_W-1:0]    dest_sel;    // destination of the word currently offered
    logic                in_range;    // destination names a real channel
    logic [CHANNELS-1:0] hit;         // one-hot destination decode
    logic [CHANNELS-1:0] slot_open;   // channel can take a word this cycle
    logic                accept;      // word transferred at this edge
    logic [7:0]          drop_q;
    logic [7:0]          drop_d;

`ifdef DEMUX_ROUNDROBIN_EN
    logic [SEL_W-1:0] rr_q;
    logic [SEL_W-1:0] rr_d;
    logic             unused_in_sel;

    // The explicit select has no role when the pointer chooses the channel.
    assign unused_in_sel = ^in_sel;
    assign dest_sel      = rr_q;

    // Pointer advances once per accepted word and wraps at the last channel.
    always_comb begin
        rr_d = rr_q;
        if (accept) begin
            if (rr_q == SEL_W'(CHANNELS - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = rr_q + SEL_W'(1);
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    assign dest_sel = in_sel;
`endif

    assign in_range = ({1'b0, dest_sel} < CHAN_LIM);

    // Decode the destination and work out which channels have room.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_decode
        assign hit[gi]       = in_range && (dest_sel == SEL_W'(gi));
        assign slot_open[gi] = ~out_valid[gi] | out_ready[gi];
    end

    // Out-of-range words are always taken (and dropped); otherwise the
    // addressed channel must be empty or draining in this same cycle.
    assign in_ready = ~in_range | (|(hit & slot_open));
    assign accept   = in_valid & in_ready;

    // Saturating count of words discarded for an out-of-range destination.
    always_comb begin
        drop_d = drop_q;
        if (accept && !in_range && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;

    // One EMPTY/FULL holding slot per output channel.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        chan_state_e      state_q;
        chan_state_e      state_d;
        logic [WIDTH-1:0] data_q;
        logic             load;

        // Next state: fill when empty, pass through when draining and
        // re-addressed, empty when drained without a new word.
        always_comb begin
            state_d = state_q;
            load    = 1'b0;
            case (state_q)
                EMPTY: begin
                    if (accept && hit[gi]) begin
                        state_d = FULL;
                        load    = 1'b1;
                    end
                end
                FULL: begin
                    if (out_ready[gi]) begin
                        if (accept && hit[gi]) begin
                            load = 1'b1;
                        end else begin
                            state_d = EMPTY;
                        end
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        // Slot state and data; data only changes on a load, so a held word
        // stays stable until consumed.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= EMPTY;
                data_q  <= '0;
            end else begin
                state_q <= state_d;
                if (load) begin
                    data_q <= in_data;
                end
            end
        end

        assign out_valid[gi]                = (state_q == FULL);
        assign out_data[gi*WIDTH +: WIDTH]  = data_q;
    end

endmodule

// File: tb/tb_demux_router.sv
// Testbench for demux_router: two instances (4 channels and 3 channels),
// directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a per-channel holding-slot model.
module tb_demux_router;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data   [2];
    logic [1:0] in_sel    [2];
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [3:0] out_ready [2];

    logic [31:0] out_data4;
    logic [3:0]  out_valid4;
    logic [7:0]  drop4;
    logic [23:0] out_data3;
    logic [2:0]  out_valid3;
    logic [7:0]  drop3;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    bit check_en = 0;

    // Reference model state
    bit         m_held [2][4];
    logic [7:0] m_data [2][4];
    int         m_drop [2];
    int         m_ptr  [2];
    bit         m_acc  [2];

    // Words seen leaving each channel (value and cycle)
    logic [7:0] rx_log [2][4][$];
    int         rx_cyc [2][4][$];

    demux_router #(.WIDTH(8), .CHANNELS(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data[0]),
        .in_sel     (in_sel[0]),
        .in_valid   (in_valid[0]),
        .in_ready   (in_ready[0]),
        .out_data   (out_data4),
        .out_valid  (out_valid4),
        .out_ready  (out_ready[0]),
        .drop_count (drop4)
    );

    demux_router #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data[1]),
        .in_sel     (in_sel[1]),
        .in_valid   (in_valid[1]),
        .in_ready   (in_ready[1]),
        .out_data   (out_data3),
        .out_valid  (out_valid3),
        .out_ready  (out_ready[1][2:0]),
        .drop_count (drop3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int nch_of(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic int dest_of(input int d);
`ifdef DEMUX_ROUNDROBIN_EN
        return m_ptr[d];
`else
        return int'(in_sel[d]);
`endif
    endfunction

    // Ready rule: out-of-range always ready, else slot empty or draining.
    function automatic bit exp_rdy(input int d);
        int dest;
        dest = dest_of(d);
        if (dest >= nch_of(d)) return 1'b1;
        return !m_held[d][dest] || out_ready[d][dest];
    endfunction

    function automatic logic get_valid(input int d, input int c);
        return (d == 0) ? out_valid4[c] : out_valid3[c];
    endfunction

    function automatic logic [7:0] get_data(input int d, input int c);
        return (d == 0) ? out_data4[c*8 +: 8] : out_data3[c*8 +: 8];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) begin
                m_held[d][c] = 1'b0;
                m_data[d][c] = 8'h00;
            end
            m_drop[d] = 0;
            m_ptr[d]  = 0;
            m_acc[d]  = 1'b0;
        end
    endtask

    task automatic model_step(input int d);
        int  dest;
        bit  acc;
        dest = dest_of(d);
        acc  = in_valid[d] && exp_rdy(d);
        for (int c = 0; c < nch_of(d); c++) begin
            if (m_held[d][c] && out_ready[d][c]) m_held[d][c] = 1'b0;
        end
        if (acc) begin
            if (dest < nch_of(d)) begin
                m_held[d][dest] = 1'b1;
                m_data[d][dest] = in_data[d];
            end else if (m_drop[d] < 255) begin
                m_drop[d]++;
            end
            m_ptr[d] = (m_ptr[d] + 1) % nch_of(d);
        end
        m_acc[d] = acc;
    endtask

    // Model advances on each rising edge; reset clears it immediately.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            cyc++;
            model_step(0);
            model_step(1);
        end
    end

    // Per-cycle comparison and output logging on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < nch_of(d); c++) begin
                    if (get_valid(d, c) && out_ready[d][c]) begin
                        rx_log[d][c].push_back(get_data(d, c));
                        rx_cyc[d][c].push_back(cyc);
                    end
                end
                if (check_en) begin
                    for (int c = 0; c < nch_of(d); c++) begin
                        chk($sformatf("valid d%0d c%0d", d, c), 32'(get_valid(d, c)), 32'(m_held[d][c]));
                        if (m_held[d][c])
                            chk($sformatf("data d%0d c%0d", d, c), 32'(get_data(d, c)), 32'(m_data[d][c]));
                    end
                    chk($sformatf("in_ready d%0d", d), 32'(in_ready[d]), 32'(exp_rdy(d)));
                    chk($sformatf("drop d%0d", d), (d == 0) ? 32'(drop4) : 32'(drop3), 32'(m_drop[d]));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [7:0] data, input logic [1:0] sel);
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        in_sel[d]   = sel;
        #1;
        chk("send in_ready", 32'(in_ready[d]), 32'd1);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic clear_logs();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 4; c++) begin
                rx_log[d][c].delete();
                rx_cyc[d][c].delete();
            end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_data[d] = 8'h00; in_sel[d] = 2'd0; in_valid[d] = 1'b0; out_ready[d] = 4'h0;
        end
        #1;
        chk("reset valid4", 32'(out_valid4), 32'h0);
        chk("reset data4", out_data4, 32'h0);
        chk("reset drop4", 32'(drop4), 32'h0);
        chk("reset valid3", 32'(out_valid3), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        check_en = 1'b1;

`ifndef DEMUX_ROUNDROBIN_EN
        // Routing with all consumers stalled
        send(0, 8'hA5, 2'd1);
        send(0, 8'h3C, 2'd3);
        in_valid[0] = 1'b1; in_data[0] = 8'h77; in_sel[0] = 2'd1;
        #1;
        chk("route blocked in_ready", 32'(in_ready[0]), 32'd0);
        in_valid[0] = 1'b0;
        chk("route valid", 32'(out_valid4), 32'b1010);
        chk("route ch1", 32'(out_data4[15:8]), 32'hA5);
        chk("route ch3", 32'(out_data4[31:24]), 32'h3C);
        out_ready[0] = 4'hF; step(); step(); out_ready[0] = 4'h0;

        // Pass-through and full-rate stream on channel 0
        send(0, 8'h11, 2'd0);
        chk("pt held", 32'(out_data4[7:0]), 32'h11);
        out_ready[0] = 4'b0001;
        send(0, 8'h22, 2'd0);
        chk("pt valid", 32'(out_valid4[0]), 32'd1);
        chk("pt data", 32'(out_data4[7:0]), 32'h22);
        clear_logs();
        for (int i = 1; i <= 16; i++) send(0, 8'(i), 2'd0);
        step(); step();
        chk("stream count", 32'(rx_log[0][0].size()), 32'd17);
        if (rx_log[0][0].size() == 17) begin
            chk("stream first", 32'(rx_log[0][0][0]), 32'h22);
            for (int i = 1; i <= 16; i++) begin
                chk($sformatf("stream word %0d", i), 32'(rx_log[0][0][i]), 32'(i));
                chk($sformatf("stream gap %0d", i), 32'(rx_cyc[0][0][i] - rx_cyc[0][0][0]), 32'(i));
            end
        end
        out_ready[0] = 4'h0;

        // Independent drain
        send(0, 8'h5A, 2'd0);
        send(0, 8'h6B, 2'd2);
        chk("drain before", 32'(out_valid4), 32'b0101);
        out_ready[0] = 4'b0100; step(); out_ready[0] = 4'h0;
        chk("drain after", 32'(out_valid4), 32'b0001);
        chk("drain ch0", 32'(out_data4[7:0]), 32'h5A);
        out_ready[0] = 4'hF; step(); out_ready[0] = 4'h0;

        // Out-of-range drops on the 3-channel instance
        in_valid[1] = 1'b1; in_sel[1] = 2'd3;
        for (int i = 0; i < 260; i++) begin
            in_data[1] = 8'($urandom);
            #1;
            chk("oor in_ready", 32'(in_ready[1]), 32'd1);
            step();
        end
        in_valid[1] = 1'b0;
        chk("oor drop sat", 32'(drop3), 32'd255);
        chk("oor no valid", 32'(out_valid3), 32'd0);
`endif

        // Reset while channel 2 holds a word
        send(0, 8'h99, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst valid4", 32'(out_valid4), 32'h0);
        chk("midrst data4", out_data4, 32'h0);
        chk("midrst drop4", 32'(drop4), 32'h0);
        chk("midrst drop3", 32'(drop3), 32'h0);
        step();
        rst_n = 1'b1;

`ifdef DEMUX_ROUNDROBIN_EN
        // Round-robin distribution on the 3-channel instance
        clear_logs();
        out_ready[1] = 4'hF;
        for (int i = 0; i < 6; i++) send(1, 8'(8'h10 + i), 2'($urandom_range(0, 3)));
        step(); step();
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("rr count c%0d", c), 32'(rx_log[1][c].size()), 32'd2);
            if (rx_log[1][c].size() == 2) begin
                chk($sformatf("rr c%0d first", c), 32'(rx_log[1][c][0]), 32'(8'h10 + c));
                chk($sformatf("rr c%0d second", c), 32'(rx_log[1][c][1]), 32'(8'h13 + c));
            end
        end
        out_ready[1] = 4'h0;
        chk("rr no drop", 32'(drop3), 32'd0);
`endif

        // Randomized traffic, honouring the source hold rule
        for (int n = 0; n < 3000; n++) begin
            for (int d = 0; d < 2; d++) begin
                if (!in_valid[d] || m_acc[d]) begin
                    in_valid[d] = ($urandom_range(0, 3) != 0);
                    in_data[d]  = 8'($urandom);
                    in_sel[d]   = 2'($urandom_range(0, 3));
                end
                out_ready[d] = 4'($urandom);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
